uart_reg_bank: RTL and testbench
================================

// Module: uart_reg_bank
// PURPOSE
//   Parametrised successor to the single-byte UART->LED latch. Consumes the byte stream from
//   uart_rx (data/data_valid), parses framed write packets and updates one of NUM_CH output
//   registers, each DATA_W bits wide. Sits between uart_rx and the board outputs (LEDs, etc.).
//   Adds addressing, broadcast, inter-byte timeout and error reporting.
// PARAMETERS
//   NUM_CH      4       number of output channels, 1..254
//   DATA_W      8       bits per channel; multiple of 8, 8..32
//   TIMEOUT_CYC 100000  idle clk cycles allowed between bytes of one frame, >=2
//   SYNC_BYTE   8'hA5   frame start marker
// PORTS
//   clk        in   1              system clock
//   rst        in   1              synchronous reset, active-high
//   in_data    in   8              received byte (uart_rx data)
//   in_valid   in   1              1-cycle strobe, in_data valid (uart_rx data_valid)
//   ch_out     out  NUM_CH*DATA_W  channel registers; channel i at [i*DATA_W +: DATA_W]
//   wr_strobe  out  NUM_CH         1-cycle pulse per channel written
//   frame_err  out  1              1-cycle pulse on any rejected frame
//   err_count  out  8              rejected-frame count, saturates at 255
// BEHAVIOUR
//   Reset: ch_out=0, wr_strobe=0, frame_err=0, err_count=0, FSM=IDLE, partial frame dropped.
//   Frame: SYNC_BYTE, ADDR, DATA_W/8 data bytes MSB first [, CHK if CRC option enabled].
//   FSM: IDLE -(byte==SYNC)-> ADDR -(byte)-> DATA -(last data byte)-> CHK or IDLE(commit);
//     CHK -(byte)-> IDLE(commit or error). Bytes other than SYNC in IDLE: ignored, no error.
//   A SYNC byte inside a frame is treated as data, not a restart.
//   ADDR < NUM_CH: write that channel. ADDR==8'hFF: broadcast to all channels.
//     Any other ADDR: frame continues to be consumed, then rejected at the end.
//   Commit: last byte accepted at cycle t -> ch_out and wr_strobe update at t+1 (registered).
//     Broadcast asserts all wr_strobe bits.
//   Reject: no ch_out change. frame_err pulses at t+1. err_count+1, saturating at 255.
//   Timeout: counter clears on each in_valid and while in IDLE. It counts in other states.
//     When it reaches TIMEOUT_CYC-1 -> IDLE and reject (frame_err/err_count as above).
//     in_valid in the same cycle as expiry: the byte wins and the counter clears.
//   Single-channel data assembly: shift register; channel registers are written only at commit.
// CONFIGURATION
//   UART_REG_BANK_CHK_EN defined: CHK byte required; CHK = XOR of ADDR and all data bytes.
//     Mismatch -> reject.
//   Undefined: no CHK state; the frame ends after the last data byte.
// STRUCTURE
//   Package egc_pkg: FSM state typedef (IDLE, ADDR, DATA, CHK), SYNC default, BCAST_ADDR=8'hFF.
//   Sub-module uart_frame_parser: FSM, timeout counter, byte count, checksum.
//     Emits commit_valid/commit_addr/commit_data/commit_err for one cycle.
//   Top uart_reg_bank: channel register array, wr_strobe, frame_err, err_count.
// TESTING
//   1 Reset then A5 02 3C -> ch_out[2]=8'h3C, wr_strobe=4'b0100 for 1 cycle, others 0.
//   2 A5 FF 81 -> all four channels =8'h81, wr_strobe=4'hF, err_count stays 0.
//   3 A5 07 55 (NUM_CH=4) -> no write, frame_err pulse, err_count=1.
//   4 A5 01 then no byte for TIMEOUT_CYC cycles, then 22 -> reject and err_count+1.
//     The 22 is ignored in IDLE; ch_out unchanged.
//   5 DATA_W=16: A5 00 12 34 -> ch_out[0]=16'h1234. Assert rst after A5 00 12 -> all zero.
//     The next 34 is ignored.
//   6 CHK_EN: A5 01 F0 F1 -> write 8'hF0. Then A5 01 F0 00 -> frame_err, ch_out[1] unchanged.
//   Also: 256 bad frames -> err_count holds at 255.

Source files
------------

// File: rtl/egc_pkg.sv
// Shared constants and FSM state encoding for the UART register bank.
package egc_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t ADDR = 2'd1;
   localparam state_t DATA = 2'd2;
   localparam state_t CHK  = 2'd3;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
   localparam logic [7:0] BCAST_ADDR   = 8'hFF;

endpackage

// File: rtl/uart_frame_parser.sv
// Frame parser: SYNC, ADDR, data bytes MSB first, optional XOR check byte.
// UART_REG_BANK_CHK_EN enables the trailing check byte.
module uart_frame_parser
   import egc_pkg::*;
#(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned TIMEOUT_CYC = 100000,
   parameter logic [7:0]  SYNC_BYTE   = SYNC_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              commit_valid,
   output logic [7:0]        commit_addr,
   output logic [DATA_W-1:0] commit_data,
   output logic              commit_err
);

   localparam int unsigned NB = DATA_W / 8;
   localparam int unsigned TW = $clog2(TIMEOUT_CYC);

   state_t            r_state, w_state_d;
   logic [7:0]        r_addr, w_addr_d;
   logic [DATA_W-1:0] r_data, w_data_d, w_shifted;
   logic [1:0]        r_cnt, w_cnt_d;
   logic [TW-1:0]     r_tmo;
   logic              w_addr_ok, w_expired;
`ifdef UART_REG_BANK_CHK_EN
   logic [7:0]        r_chk, w_chk_d;
`endif

   assign w_shifted = (r_data << 8) | DATA_W'(in_data);
   assign w_addr_ok = (32'(r_addr) < NUM_CH) || (r_addr == BCAST_ADDR);
   // A byte arriving on the expiry cycle takes precedence over the timeout.
   assign w_expired = (r_state != IDLE) && !in_valid && (r_tmo == TW'(TIMEOUT_CYC - 1));
   assign commit_addr = r_addr;
`ifdef UART_REG_BANK_CHK_EN
   assign commit_data = r_data;
`else
   assign commit_data = w_shifted;
`endif

   always_comb begin
      w_state_d    = r_state;
      w_addr_d     = r_addr;
      w_data_d     = r_data;
      w_cnt_d      = r_cnt;
      commit_valid = 1'b0;
      commit_err   = 1'b0;
`ifdef UART_REG_BANK_CHK_EN
      w_chk_d      = r_chk;
`endif
      case (r_state)
         IDLE: if (in_valid && in_data == SYNC_BYTE) w_state_d = ADDR;
         ADDR: if (in_valid) begin
            w_addr_d  = in_data;
            w_cnt_d   = 2'd0;
            w_state_d = DATA;
`ifdef UART_REG_BANK_CHK_EN
            w_chk_d   = in_data;
`endif
         end
         DATA: if (in_valid) begin
            w_data_d = w_shifted;
            w_cnt_d  = r_cnt + 2'd1;
`ifdef UART_REG_BANK_CHK_EN
            w_chk_d  = r_chk ^ in_data;
            if (r_cnt == 2'(NB - 1)) w_state_d = CHK;
`else
            if (r_cnt == 2'(NB - 1)) begin
               w_state_d    = IDLE;
               commit_valid = 1'b1;
               commit_err   = !w_addr_ok;
            end
`endif
         end
         CHK: begin
`ifdef UART_REG_BANK_CHK_EN
            if (in_valid) begin
               w_state_d    = IDLE;
               commit_valid = 1'b1;
               commit_err   = !w_addr_ok || (in_data != r_chk);
            end
`else
            w_state_d = IDLE;
`endif
         end
         default: w_state_d = IDLE;
      endcase
      if (w_expired) begin
         w_state_d    = IDLE;
         commit_valid = 1'b1;
         commit_err   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_data  <= '0;
         r_cnt   <= '0;
         r_tmo   <= '0;
`ifdef UART_REG_BANK_CHK_EN
         r_chk   <= '0;
`endif
      end else begin
         r_state <= w_state_d;
         r_addr  <= w_addr_d;
         r_data  <= w_data_d;
         r_cnt   <= w_cnt_d;
         r_tmo   <= (in_valid || r_state == IDLE) ? '0 : r_tmo + 1'b1;
`ifdef UART_REG_BANK_CHK_EN
         r_chk   <= w_chk_d;
`endif
      end
   end

endmodule

// File: rtl/uart_reg_bank.sv
// Addressed UART register bank: channel registers, write strobes, error reporting.
// Check-byte framing is selected by UART_REG_BANK_CHK_EN (see uart_frame_parser).
module uart_reg_bank
   import egc_pkg::*;
#(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned TIMEOUT_CYC = 100000,
   parameter logic [7:0]  SYNC_BYTE   = SYNC_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               in_data,
   input  logic                     in_valid,
   output logic [NUM_CH*DATA_W-1:0] ch_out,
   output logic [NUM_CH-1:0]        wr_strobe,
   output logic                     frame_err,
   output logic [7:0]               err_count
);

   logic              w_commit_valid, w_commit_err;
   logic [7:0]        w_commit_addr;
   logic [DATA_W-1:0] w_commit_data;

   logic [DATA_W-1:0] r_ch [NUM_CH];
   logic [NUM_CH-1:0] r_strobe;
   logic              r_frame_err;
   logic [7:0]        r_err_count;

   uart_frame_parser #(
      .NUM_CH      (NUM_CH),
      .DATA_W      (DATA_W),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .SYNC_BYTE   (SYNC_BYTE)
   ) u_parser (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .commit_valid (w_commit_valid),
      .commit_addr  (w_commit_addr),
      .commit_data  (w_commit_data),
      .commit_err   (w_commit_err)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NUM_CH); i++) r_ch[i] <= '0;
         r_strobe    <= '0;
         r_frame_err <= 1'b0;
         r_err_count <= '0;
      end else begin
         r_strobe    <= '0;
         r_frame_err <= 1'b0;
         if (w_commit_valid) begin
            if (w_commit_err) begin
               r_frame_err <= 1'b1;
               if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            end else begin
               for (int i = 0; i < int'(NUM_CH); i++) begin
                  if (w_commit_addr == BCAST_ADDR || w_commit_addr == 8'(i)) begin
                     r_ch[i]     <= w_commit_data;
                     r_strobe[i] <= 1'b1;
                  end
               end
            end
         end
      end
   end

   for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
      assign ch_out[g*DATA_W +: DATA_W] = r_ch[g];
   end

   assign wr_strobe = r_strobe;
   assign frame_err = r_frame_err;
   assign err_count = r_err_count;

endmodule

// File: tb/tb_uart_reg_bank.sv
// Scoreboard bench: two banks (8-bit and 16-bit channels); expected events queued by stimulus.
module tb_uart_reg_bank;

   typedef struct {
      logic [3:0]  strobe;
      logic        err;
      logic [63:0] ch;
      logic [7:0]  ec;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst1, rst2;
   logic [7:0]  in_data1, in_data2;
   logic        in_valid1, in_valid2;
   logic [31:0] ch1;
   logic [63:0] ch2;
   logic [3:0]  st1, st2;
   logic        fe1, fe2;
   logic [7:0]  ec1, ec2;

   exp_t q1[$];
   exp_t q2[$];
   exp_t e1, e2;
   int   n_checks = 0;
   int   n_pass   = 0;
   logic [7:0] exp_ec;

   always #5 clk = ~clk;

   uart_reg_bank #(.NUM_CH(4), .DATA_W(8), .TIMEOUT_CYC(16), .SYNC_BYTE(8'hA5)) u_dut1 (
      .clk(clk), .rst(rst1), .in_data(in_data1), .in_valid(in_valid1),
      .ch_out(ch1), .wr_strobe(st1), .frame_err(fe1), .err_count(ec1)
   );

   uart_reg_bank #(.NUM_CH(4), .DATA_W(16), .TIMEOUT_CYC(16), .SYNC_BYTE(8'hA5)) u_dut2 (
      .clk(clk), .rst(rst2), .in_data(in_data2), .in_valid(in_valid2),
      .ch_out(ch2), .wr_strobe(st2), .frame_err(fe2), .err_count(ec2)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send1(input logic [7:0] d);
      in_data1 = d; in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
   endtask

   task automatic send2(input logic [7:0] d);
      in_data2 = d; in_valid2 = 1'b1;
      @(posedge clk); #1;
      in_valid2 = 1'b0;
   endtask

   task automatic push1(input logic [3:0] s, input logic err, input logic [31:0] ch,
                        input logic [7:0] ec);
      exp_t e;
      e.strobe = s; e.err = err; e.ch = {32'h0, ch}; e.ec = ec;
      q1.push_back(e);
   endtask

   task automatic push2(input logic [3:0] s, input logic err, input logic [63:0] ch,
                        input logic [7:0] ec);
      exp_t e;
      e.strobe = s; e.err = err; e.ch = ch; e.ec = ec;
      q2.push_back(e);
   endtask

   task automatic frame8(input logic [7:0] a, input logic [7:0] d);
      send1(8'hA5); send1(a); send1(d);
`ifdef UART_REG_BANK_CHK_EN
      send1(a ^ d);
`endif
      idle(2);
   endtask

   always @(negedge clk) begin
      if (st1 != 4'h0 || fe1) begin
         if (q1.size() == 0) begin
            n_checks++;
            $display("FAIL dut1_unexpected: strobe %0h err %0b, none expected", st1, fe1);
         end else begin
            e1 = q1.pop_front();
            check("dut1_event", {83'h0, st1, fe1, ch1, ec1}, {83'h0, e1.strobe, e1.err,
                  e1.ch[31:0], e1.ec});
         end
      end
      if (st2 != 4'h0 || fe2) begin
         if (q2.size() == 0) begin
            n_checks++;
            $display("FAIL dut2_unexpected: strobe %0h err %0b, none expected", st2, fe2);
         end else begin
            e2 = q2.pop_front();
            check("dut2_event", {51'h0, st2, fe2, ch2, ec2}, {51'h0, e2.strobe, e2.err,
                  e2.ch, e2.ec});
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst1 = 1'b1; rst2 = 1'b1;
      in_data1 = 8'h00; in_data2 = 8'h00;
      in_valid1 = 1'b0; in_valid2 = 1'b0;
      idle(3);
      rst1 = 1'b0; rst2 = 1'b0;
      idle(2);

      check("rst_ch1", 128'(ch1), 128'h0);
      check("rst_st1", 128'(st1), 128'h0);
      check("rst_fe1", 128'(fe1), 128'h0);
      check("rst_ec1", 128'(ec1), 128'h0);
      check("rst_ch2", 128'(ch2), 128'h0);
      check("rst_ec2", 128'(ec2), 128'h0);

      // single channel write
      push1(4'b0100, 1'b0, 32'h003C_0000, 8'd0);
      frame8(8'h02, 8'h3C);
      // broadcast
      push1(4'hF, 1'b0, 32'h8181_8181, 8'd0);
      frame8(8'hFF, 8'h81);
      // bad address
      push1(4'h0, 1'b1, 32'h8181_8181, 8'd1);
      frame8(8'h07, 8'h55);
      check("bad_addr_ec", 128'(ec1), 128'd1);

      // inter-byte timeout, then stray byte in IDLE
      push1(4'h0, 1'b1, 32'h8181_8181, 8'd2);
      send1(8'hA5); send1(8'h01);
      idle(20);
      send1(8'h22);
      idle(4);
      check("timeout_ch", 128'(ch1), 128'h8181_8181);
      check("timeout_ec", 128'(ec1), 128'd2);
      exp_ec = 8'd2;

`ifdef UART_REG_BANK_CHK_EN
      push1(4'b0010, 1'b0, 32'h8181_F081, 8'd2);
      send1(8'hA5); send1(8'h01); send1(8'hF0); send1(8'hF1);
      idle(2);
      push1(4'h0, 1'b1, 32'h8181_F081, 8'd3);
      send1(8'hA5); send1(8'h01); send1(8'hF0); send1(8'h00);
      idle(2);
      check("chk_bad_ch", 128'(ch1), 128'h8181_F081);
      exp_ec = 8'd3;
`endif

      // 16-bit channel, MSB first
`ifdef UART_REG_BANK_CHK_EN
      push2(4'b0001, 1'b0, 64'h0000_0000_0000_1234, 8'd0);
      send2(8'hA5); send2(8'h00); send2(8'h12); send2(8'h34); send2(8'h26);
`else
      push2(4'b0001, 1'b0, 64'h0000_0000_0000_1234, 8'd0);
      send2(8'hA5); send2(8'h00); send2(8'h12); send2(8'h34);
`endif
      idle(2);
      check("w16_ch", 128'(ch2), 128'h1234);
      // reset mid-frame drops the partial frame
      send2(8'hA5); send2(8'h00); send2(8'h12);
      rst2 = 1'b1;
      idle(1);
      rst2 = 1'b0;
      idle(1);
      check("w16_rst_ch", 128'(ch2), 128'h0);
      send2(8'h34);
      idle(4);
      check("w16_after_ch", 128'(ch2), 128'h0);
      check("w16_after_ec", 128'(ec2), 128'h0);

      // error counter saturation
      for (int i = 0; i < 256; i++) begin
         exp_ec = (exp_ec == 8'hFF) ? 8'hFF : exp_ec + 8'd1;
`ifdef UART_REG_BANK_CHK_EN
         push1(4'h0, 1'b1, 32'h8181_F081, exp_ec);
`else
         push1(4'h0, 1'b1, 32'h8181_8181, exp_ec);
`endif
         frame8(8'h07, 8'h55);
      end
      check("sat_ec", 128'(ec1), 128'd255);

      idle(4);
      check("q1_drained", 128'(q1.size()), 128'd0);
      check("q2_drained", 128'(q2.size()), 128'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
